// File: rtl/rename_ckpt_if.sv
// rename_ckpt_if: decode, commit and branch-resolution signals of the rename checkpoint unit
interface rename_ckpt_if #(
    parameter int AW = 4,
    parameter int PW = 7,
    parameter int CW = 2
);
    logic          rename_v_i;
    logic          rename_ready_o;
    logic [AW-1:0] src1_i;
    logic [AW-1:0] src2_i;
    logic [AW-1:0] dest_i;
    logic          w_v_i;
    logic          ckpt_req_i;
    logic [PW-1:0] src1_p_o;
    logic [PW-1:0] src2_p_o;
    logic [PW-1:0] dest_p_o;
    logic [PW-1:0] prev_p_o;
    logic [CW-1:0] ckpt_id_o;
    logic          commit_v_i;
    logic          commit_w_v_i;
    logic [PW-1:0] commit_freed_i;
    logic          resolve_v_i;
    logic [CW-1:0] resolve_ckpt_i;
    logic          mispredict_v_i;
    logic [CW-1:0] mispredict_ckpt_i;
    logic [PW:0]   fl_count_o;
    modport master (
        output rename_v_i, src1_i, src2_i, dest_i, w_v_i, ckpt_req_i,
               commit_v_i, commit_w_v_i, commit_freed_i,
               resolve_v_i, resolve_ckpt_i, mispredict_v_i, mispredict_ckpt_i,
        input  rename_ready_o, src1_p_o, src2_p_o, dest_p_o, prev_p_o, ckpt_id_o, fl_count_o
    );
    modport slave (
        input  rename_v_i, src1_i, src2_i, dest_i, w_v_i, ckpt_req_i,
               commit_v_i, commit_w_v_i, commit_freed_i,
               resolve_v_i, resolve_ckpt_i, mispredict_v_i, mispredict_ckpt_i,
        output rename_ready_o, src1_p_o, src2_p_o, dest_p_o, prev_p_o, ckpt_id_o, fl_count_o
    );
endinterface

// File: rtl/rename_ckpt_unit.sv
// rename_ckpt_unit: speculative register renamer with a circular freelist and per-branch
// checkpoints of the map table and freelist read pointer for single-cycle mispredict recovery
module rename_ckpt_unit #(
    parameter int NUM_ARCH_REG = 16,
    parameter int NUM_PHYS_REG = 128,
    parameter int NUM_CKPT     = 4
) (
    input logic          clk_i,
    input logic          reset_i,
    rename_ckpt_if.slave rif
);
    localparam int PW = $clog2(NUM_PHYS_REG);
    localparam int CW = $clog2(NUM_CKPT);
    localparam int FW = PW + 1;
    localparam int NUM_FREE = NUM_PHYS_REG - NUM_ARCH_REG;

    logic [PW-1:0]       lut     [NUM_ARCH_REG];
    logic [PW-1:0]       lut_nx  [NUM_ARCH_REG];
    logic [PW-1:0]       fl      [NUM_PHYS_REG];
    logic [PW-1:0]       ckpt_lut[NUM_CKPT][NUM_ARCH_REG];
    logic [PW:0]         ckpt_rd [NUM_CKPT];
    logic [PW:0]         rd_ptr, wr_ptr, rd_nx, fl_count;
    logic [NUM_CKPT-1:0] ckpt_vld, ckpt_vld_nx, squash;
    logic [CW-1:0]       ckpt_tail, span;
    logic                fire, alloc, take_ckpt, restore, push;

    assign fl_count  = wr_ptr - rd_ptr;
    assign fire      = rif.rename_v_i && rif.rename_ready_o;
    assign alloc     = fire && rif.w_v_i;
    assign take_ckpt = fire && rif.ckpt_req_i;
    assign restore   = rif.mispredict_v_i && ckpt_vld[rif.mispredict_ckpt_i];
    assign push      = rif.commit_v_i && rif.commit_w_v_i;
    assign rd_nx     = rd_ptr + FW'(alloc);

    assign rif.rename_ready_o = !reset_i && !rif.mispredict_v_i && (!rif.w_v_i || fl_count != '0) &&
                                (!rif.ckpt_req_i || !ckpt_vld[ckpt_tail]);
    assign rif.fl_count_o = reset_i ? FW'(NUM_FREE) : fl_count;
    assign rif.src1_p_o   = lut[rif.src1_i];
    assign rif.src2_p_o   = lut[rif.src2_i];
    assign rif.prev_p_o   = lut[rif.dest_i];
    assign rif.dest_p_o   = rif.w_v_i ? fl[rd_ptr[PW-1:0]] : '0;
    assign rif.ckpt_id_o  = ckpt_tail;

    always_comb begin
        lut_nx = lut;
        if (alloc) lut_nx[rif.dest_i] = fl[rd_ptr[PW-1:0]];
    end

    // Squash the mispredicted slot and all younger ones; tail==slot with slot valid means the ring is full.
    always_comb begin
        span   = ckpt_tail - rif.mispredict_ckpt_i;
        squash = '0;
        for (int i = 0; i < NUM_CKPT; i++)
            squash[i] = restore && (span == '0 || CW'(CW'(i) - rif.mispredict_ckpt_i) < span);
        ckpt_vld_nx = ckpt_vld & ~squash;
        if (rif.resolve_v_i) ckpt_vld_nx[rif.resolve_ckpt_i] = 1'b0;
        if (take_ckpt) ckpt_vld_nx[ckpt_tail] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_ARCH_REG; i++) lut[i] <= PW'(i);
            for (int i = 0; i < NUM_PHYS_REG; i++) fl[i] <= PW'(i + NUM_ARCH_REG);
            rd_ptr    <= '0;
            wr_ptr    <= FW'(NUM_FREE);
            ckpt_vld  <= '0;
            ckpt_tail <= '0;
        end else begin
            if (push) begin
                fl[wr_ptr[PW-1:0]] <= rif.commit_freed_i;
                wr_ptr             <= wr_ptr + FW'(1);
            end
            if (restore) begin
                lut       <= ckpt_lut[rif.mispredict_ckpt_i];
                rd_ptr    <= ckpt_rd[rif.mispredict_ckpt_i];
                ckpt_tail <= rif.mispredict_ckpt_i;
            end else begin
                lut    <= lut_nx;
                rd_ptr <= rd_nx;
                if (take_ckpt) ckpt_tail <= ckpt_tail + CW'(1);
            end
            ckpt_vld <= ckpt_vld_nx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (take_ckpt) begin
            ckpt_lut[ckpt_tail] <= lut_nx;
            ckpt_rd[ckpt_tail]  <= rd_nx;
        end
    end
endmodule
